// File: rtl/chacha_pkg.sv
// chacha_pkg: shared types, ChaCha20 "expand 32-byte k" constants and FSM states
package chacha_pkg;
    typedef logic [31:0] word_t;
    typedef word_t [3:0][3:0] matrix_t;
    localparam word_t CHACHA_CONST [4] = '{32'h6170_7865, 32'h3320_646e, 32'h7962_2d32, 32'h6b20_6574};
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_STREAM} state_t;
endpackage

// File: rtl/chacha_state_assemble.sv
// chacha_state_assemble: maps key, nonce and block counter onto the 4x4 ChaCha20 input state
module chacha_state_assemble
    import chacha_pkg::*;
(
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  word_t        counter,
    output matrix_t      matrix
);
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            matrix[0][i] = CHACHA_CONST[i];
            matrix[1][i] = key[32*i +: 32];
            matrix[2][i] = key[32*(i+4) +: 32];
        end
        matrix[3][0] = counter;
        for (int i = 0; i < 3; i++) matrix[3][i+1] = nonce[32*i +: 32];
    end
endmodule

// File: rtl/chacha_keystream_xor.sv
// chacha_keystream_xor: drives the ChaCha20 block core and XORs each captured
// keystream block into a valid/ready word stream, stepping the block counter.
module chacha_keystream_xor
    import chacha_pkg::*;
#(
    parameter logic [31:0] INIT_CTR_MAX = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  init_counter,
    output matrix_t      core_matrix,
    output logic         core_set,
    input  matrix_t      core_block,
    input  logic         core_ready,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic [31:0]  din_data,
    input  logic         din_last,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic [31:0]  dout_data,
    output logic         dout_last,
    output logic         busy,
    output logic [31:0]  blk_counter,
    output logic         ovf_err
);
    state_t       state, state_d;
    logic [255:0] key_q;
    logic [95:0]  nonce_q;
    matrix_t      ks;
    logic [3:0]   idx;
    logic         xfer, blk_end, at_max;

    chacha_state_assemble u_assemble (
        .key     (key_q),
        .nonce   (nonce_q),
        .counter (blk_counter),
        .matrix  (core_matrix)
    );

    assign xfer    = din_valid && din_ready;
    assign blk_end = xfer && !din_last && idx == 4'hf;
    assign at_max  = blk_counter == INIT_CTR_MAX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   state_d = start ? S_LOAD : S_IDLE;
            S_LOAD:   state_d = S_WAIT;
            S_WAIT:   state_d = core_ready ? S_STREAM : S_WAIT;
            S_STREAM: state_d = !xfer ? S_STREAM :
                                (din_last || (blk_end && at_max)) ? S_IDLE :
                                blk_end ? S_LOAD : S_STREAM;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        core_set  = state == S_LOAD;
        busy      = state != S_IDLE;
        din_ready = state == S_STREAM && (!dout_valid || dout_ready);
    end

    // the counter only moves at a block boundary, so core_matrix holds from LOAD to capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q       <= '0;
            nonce_q     <= '0;
            blk_counter <= '0;
            ovf_err     <= 1'b0;
            ks          <= '0;
            idx         <= '0;
            dout_valid  <= 1'b0;
            dout_data   <= '0;
            dout_last   <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                key_q       <= key;
                nonce_q     <= nonce;
                blk_counter <= init_counter;
                ovf_err     <= 1'b0;
            end
            if (state == S_WAIT && core_ready) begin
                ks  <= core_block;
                idx <= '0;
            end
            if (xfer) begin
                dout_data  <= din_data ^ ks[idx[3:2]][idx[1:0]];
                dout_last  <= din_last;
                dout_valid <= 1'b1;
                idx        <= idx + 4'd1;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
            if (blk_end && at_max)  ovf_err     <= 1'b1;
            if (blk_end && !at_max) blk_counter <= blk_counter + 32'd1;
        end
    end
endmodule

// File: tb/tb_chacha_keystream_xor.sv
// tb_chacha_keystream_xor: table-driven check of chacha_keystream_xor against a
// behavioural ChaCha20 block core and an independent keystream model.
module tb_chacha_keystream_xor;
    import chacha_pkg::*;

    localparam int CORE_LAT = 3;
    localparam int BUDGET   = 600;
    localparam int QI [8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                                 '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};

    logic         clk = 1'b0;
    logic         rst_n, start, core_ready, din_valid, din_ready, din_last;
    logic         dout_valid, dout_ready, dout_last, busy, ovf_err, core_set;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  init_counter, din_data, dout_data, blk_counter;
    matrix_t      core_matrix, core_block;

    chacha_keystream_xor #(.INIT_CTR_MAX(32'd5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .nonce(nonce),
        .init_counter(init_counter), .core_matrix(core_matrix), .core_set(core_set),
        .core_block(core_block), .core_ready(core_ready), .din_valid(din_valid),
        .din_ready(din_ready), .din_data(din_data), .din_last(din_last),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .dout_last(dout_last), .busy(busy), .blk_counter(blk_counter), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [511:0] chacha_block(input logic [511:0] s);
        logic [31:0]  x [16];
        logic [511:0] o;
        int a, b, c, d;
        for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
        for (int r = 0; r < 10; r++)
            for (int j = 0; j < 8; j++) begin
                a = QI[j][0]; b = QI[j][1]; c = QI[j][2]; d = QI[j][3];
                x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
                x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
                x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
                x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
            end
        for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + s[32*i +: 32];
        return o;
    endfunction

    function automatic logic [31:0] ks_word(input logic [255:0] k, input logic [95:0] nn,
                                            input logic [31:0] c, input int w);
        logic [511:0] s, blk;
        s[127:0]   = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
        s[383:128] = k;
        s[415:384] = c;
        s[511:416] = nn;
        blk = chacha_block(s);
        return blk[32*w +: 32];
    endfunction

    // behavioural block core: answers each core_set pulse after CORE_LAT cycles
    int lat_cnt = 0;
    int set_pulses = 0;
    always @(posedge clk) begin
        if (!rst_n) begin
            lat_cnt    <= 0;
            core_ready <= 1'b0;
        end else begin
            core_ready <= 1'b0;
            if (core_set) begin
                lat_cnt    <= CORE_LAT;
                core_block <= chacha_block(core_matrix);
                set_pulses <= set_pulses + 1;
            end else if (lat_cnt > 0) begin
                lat_cnt    <= lat_cnt - 1;
                core_ready <= lat_cnt == 1;
            end
        end
    end

    int tests = 0;
    int fails = 0;
    logic [31:0] tx [64];
    logic [31:0] rx [64];
    logic        rxl [64];
    int          rx_n;
    string pt = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, " busy"},        32'(busy), 0);
        chk({tag, " core_set"},    32'(core_set), 0);
        chk({tag, " din_ready"},   32'(din_ready), 0);
        chk({tag, " dout_valid"},  32'(dout_valid), 0);
        chk({tag, " dout_last"},   32'(dout_last), 0);
        chk({tag, " ovf_err"},     32'(ovf_err), 0);
        chk({tag, " dout_data"},   dout_data, 0);
        chk({tag, " blk_counter"}, blk_counter, 0);
    endtask

    task automatic fill(input bit rfc);
        for (int i = 0; i < 64; i++) tx[i] = rfc ? 32'h0 : 32'(i) * 32'h9e3779b9 + 32'h0badf00d;
        if (rfc) for (int b = 0; b < pt.len(); b++) tx[b/4][8*(b%4) +: 8] = pt[b];
    endtask

    task automatic do_start(input logic [31:0] c);
        init_counter = c;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic stream(input int n, input bit last, input bit stall, input bit hold,
                          output int sent, output bit tmo);
        int cyc = 0;
        sent = 0;
        rx_n = 0;
        while (cyc < BUDGET && ((sent < n && busy) || dout_valid)) begin
            din_valid  = sent < n;
            din_data   = tx[sent];
            din_last   = last && sent == n - 1;
            dout_ready = stall ? 1'($urandom_range(1)) : 1'b1;
            start      = hold && sent < n - 1;
            @(negedge clk);
            if (dout_valid && dout_ready) begin
                rx[rx_n]  = dout_data;
                rxl[rx_n] = dout_last;
                rx_n++;
            end
            if (din_valid && din_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        dout_ready = 1'b1;
        tmo = cyc >= BUDGET;
    endtask

    task automatic check_rx(input string tag, input logic [31:0] c0, input int cnt);
        for (int i = 0; i < cnt; i++)
            chk($sformatf("%s word%0d", tag, i), rx[i], tx[i] ^ ks_word(key, nonce, c0 + 32'(i / 16), i % 16));
    endtask

    task automatic run_check(input string tag, input logic [31:0] c0, input int n, input bit last,
                             input bit stall, input bit hold, input bit rfc, input int acc,
                             input logic [31:0] ce, input bit ovf, input int sets);
        logic [255:0] k0;
        logic [31:0]  c_hold;
        int base, sent;
        bit tmo;
        fill(rfc);
        k0 = key;
        base = set_pulses;
        do_start(c0);
        chk({tag, " load core_set"}, 32'(core_set), 1);
        chk({tag, " load busy"},     32'(busy), 1);
        chk({tag, " matrix w0"},     core_matrix[0][0], 32'h61707865);
        chk({tag, " matrix w4"},     core_matrix[1][0], 32'h03020100);
        chk({tag, " matrix w12"},    core_matrix[3][0], c0);
        chk({tag, " matrix w14"},    core_matrix[3][2], 32'h4a000000);
        c_hold = ~c0;
        if (hold) begin
            key = ~k0;
            init_counter = c_hold;
        end
        stream(n, last, stall, hold, sent, tmo);
        key = k0;
        chk({tag, " timeout"},     32'(tmo), 0);
        chk({tag, " accepted"},    32'(sent), 32'(acc));
        chk({tag, " outputs"},     32'(rx_n), 32'(acc));
        check_rx(tag, c0, rx_n);
        if (rx_n > 0) chk({tag, " final last"}, 32'(rxl[rx_n-1]), 32'(acc == n && last));
        if (rfc) chk({tag, " first ct"}, rx[0], 32'h9a352e6e);
        chk({tag, " blk_counter"}, blk_counter, ce);
        chk({tag, " ovf_err"},     32'(ovf_err), 32'(ovf));
        chk({tag, " busy end"},    32'(busy), 0);
        chk({tag, " din_ready end"}, 32'(din_ready), 0);
        chk({tag, " core_set pulses"}, 32'(set_pulses - base), 32'(sets));
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    typedef struct {
        logic [31:0] ctr;
        int          n;
        bit          last;
        bit          stall;
        bit          rfc;
        int          acc;
        logic [31:0] ctr_end;
        bit          ovf;
        int          sets;
    } row_t;

    row_t rows [7];

    initial begin
        int sent;
        bit tmo;
        rows[0] = '{32'd1, 29, 1'b1, 1'b0, 1'b1, 29, 32'd2, 1'b0, 2};
        rows[1] = '{32'd1, 40, 1'b1, 1'b0, 1'b0, 40, 32'd3, 1'b0, 3};
        rows[2] = '{32'd1, 40, 1'b1, 1'b1, 1'b0, 40, 32'd3, 1'b0, 3};
        rows[3] = '{32'd0, 16, 1'b1, 1'b0, 1'b0, 16, 32'd0, 1'b0, 1};
        rows[4] = '{32'd5, 20, 1'b1, 1'b0, 1'b0, 16, 32'd5, 1'b1, 1};
        rows[5] = '{32'd4, 20, 1'b1, 1'b1, 1'b0, 20, 32'd5, 1'b0, 2};
        rows[6] = '{32'd0, 17, 1'b1, 1'b1, 1'b0, 17, 32'd1, 1'b0, 2};
        for (int b = 0; b < 32; b++) key[8*b +: 8] = 8'(b);
        nonce = 96'h00000000_4a000000_00000000;
        rst_n = 1'b0; start = 1'b0; init_counter = '0;
        din_valid = 1'b0; din_data = '0; din_last = 1'b0; dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_rst("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int r = 0; r < 7; r++)
            run_check($sformatf("row%0d", r), rows[r].ctr, rows[r].n, rows[r].last, rows[r].stall,
                      1'b0, rows[r].rfc, rows[r].acc, rows[r].ctr_end, rows[r].ovf, rows[r].sets);

        // start held high through WAIT/STREAM with a different key and counter must be ignored
        run_check("ignstart", 32'd2, 8, 1'b1, 1'b0, 1'b1, 1'b0, 8, 32'd2, 1'b0, 1);

        // reset while word 7 sits in the output register
        fill(1'b0);
        do_start(32'd1);
        stream(7, 1'b0, 1'b0, 1'b0, sent, tmo);
        chk("midrst timeout", 32'(tmo), 0);
        chk("midrst outputs", 32'(rx_n), 7);
        check_rx("midrst", 32'd1, rx_n);
        din_valid = 1'b1; din_data = tx[7]; din_last = 1'b0; dout_ready = 1'b0;
        @(posedge clk); #1;
        chk("midrst w7 valid", 32'(dout_valid), 1);
        chk("midrst w7 data", dout_data, tx[7] ^ ks_word(key, nonce, 32'd1, 7));
        rst_n = 1'b0;
        #1 chk_rst("midrst");
        din_valid = 1'b0; dout_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_check("postrst", 32'd3, 5, 1'b1, 1'b0, 1'b0, 1'b0, 5, 32'd3, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
